smem_hsi_receiver: RTL and testbench

Receives the HSI bus (command word plus 64 data words per SMEM row) and reassembles each row into four DW-bit segments and a row index, presented on a valid/ready output. It models the sensor-chip end of the SMEM write path, so the bench and loopback designs can check what `smem_writer_hsi` sends. It also serves as the FPGA-side capture block when HSI is looped back. Everything runs in the HSI clock domain; there is no CDC inside.

---
 rtl/smem_hsi_receiver_pkg.sv | 14 +
 rtl/smem_hsi_receiver_if.sv | 27 ++
 rtl/smem_hsi_receiver_row_asm.sv | 64 ++++++
 rtl/smem_hsi_receiver.sv | 115 +++++++++++
 tb/tb_smem_hsi_receiver.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/smem_hsi_receiver_pkg.sv
// Shared constants and the assembly state type for the HSI row receiver.
package smem_hsi_pkg;
    localparam int HSI_WORD_W          = 32;
    localparam int ROW_ENTRIES         = 64;
    localparam int ENTRIES_PER_SEGMENT = 16;
    localparam int SEGMENTS            = ROW_ENTRIES / ENTRIES_PER_SEGMENT;
    localparam int ENTRY_W             = $clog2(ROW_ENTRIES);
    localparam logic [ENTRY_W-1:0] LAST_ENTRY = ENTRY_W'(ROW_ENTRIES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } asm_state_e;
endpackage

// File: rtl/smem_hsi_receiver_if.sv
// HSI input bus plus the valid/ready row output of the receiver.
interface smem_hsi_receiver_if
    import smem_hsi_pkg::*;
#(
    parameter int DW = 512
);
    logic [HSI_WORD_W-1:0] hsi_data;
    logic                  hsi_cmd;
    logic                  hsi_valid;
    logic                  row_valid;
    logic                  row_ready;
    logic [HSI_WORD_W-1:0] row_index;
    logic [DW-1:0]         smem_data0;
    logic [DW-1:0]         smem_data1;
    logic [DW-1:0]         smem_data2;
    logic [DW-1:0]         smem_data3;

    modport master (
        output hsi_data, hsi_cmd, hsi_valid, row_ready,
        input  row_valid, row_index, smem_data0, smem_data1, smem_data2, smem_data3
    );

    modport slave (
        input  hsi_data, hsi_cmd, hsi_valid, row_ready,
        output row_valid, row_index, smem_data0, smem_data1, smem_data2, smem_data3
    );
endinterface

// File: rtl/smem_hsi_receiver_row_asm.sv
// Row assembly: IDLE/DATA FSM, entry counter and assembly buffer.
// Word 63 is forwarded straight from the bus, so only 63 words are stored.
module smem_hsi_row_asm
    import smem_hsi_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   beat_i,
    input  logic                                   cmd_i,
    input  logic [HSI_WORD_W-1:0]                  data_i,
    output asm_state_e                             state_o,
    output logic [HSI_WORD_W-1:0]                  index_o,
    output logic                                   done_o,
    output logic [ROW_ENTRIES-1:0][HSI_WORD_W-1:0] row_o
);
    asm_state_e                            state_q;
    logic [ENTRY_W-1:0]                    entry_q;
    logic [HSI_WORD_W-1:0]                 index_q;
    logic [ROW_ENTRIES-2:0][HSI_WORD_W-1:0] buf_q;

    logic data_beat;
    assign data_beat = beat_i && !cmd_i && (state_q == DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            entry_q <= '0;
            index_q <= '0;
        end else if (beat_i) begin
            case (state_q)
                IDLE: begin
                    if (cmd_i) begin
                        index_q <= data_i;
                        entry_q <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (cmd_i) begin
                        index_q <= data_i;
                        entry_q <= '0;
                    end else if (entry_q == LAST_ENTRY) begin
                        entry_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        entry_q <= entry_q + ENTRY_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Partial rows need no clearing: every slot is rewritten before completion.
    always_ff @(posedge clk) begin
        if (data_beat && entry_q != LAST_ENTRY)
            buf_q[entry_q] <= data_i;
    end

    assign state_o = state_q;
    assign index_o = index_q;
    assign done_o  = data_beat && (entry_q == LAST_ENTRY);
    assign row_o   = {data_i, buf_q};
endmodule

// File: rtl/smem_hsi_receiver.sv
// HSI row receiver top: output buffer, handshake, error pulses, gap check.
// Optional SMEM_HSI_RX_ERR_CNT_EN adds a saturating error-cycle counter.
module smem_hsi_receiver
    import smem_hsi_pkg::*;
#(
    parameter int DW       = 512,
    parameter int IDLE_MIN = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    smem_hsi_receiver_if.slave   bus,
    output logic                 busy,
    output logic                 err_orphan,
    output logic                 err_short,
    output logic                 err_overrun,
    output logic                 err_gap
`ifdef SMEM_HSI_RX_ERR_CNT_EN
    ,
    output logic [15:0]          err_count
`endif
);
    localparam int GW = (IDLE_MIN > 0) ? $clog2(IDLE_MIN + 1) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(IDLE_MIN);

    asm_state_e                             state;
    logic [HSI_WORD_W-1:0]                  asm_index;
    logic                                   asm_done;
    logic [ROW_ENTRIES-1:0][HSI_WORD_W-1:0] asm_row;

    smem_hsi_row_asm u_asm (
        .clk     (clk),
        .reset   (reset),
        .beat_i  (bus.hsi_valid),
        .cmd_i   (bus.hsi_cmd),
        .data_i  (bus.hsi_data),
        .state_o (state),
        .index_o (asm_index),
        .done_o  (asm_done),
        .row_o   (asm_row)
    );

    logic                          row_valid_q;
    logic [HSI_WORD_W-1:0]         row_index_q;
    logic [SEGMENTS-1:0][DW-1:0]   seg_q;
    logic                          orphan_q, short_q, overrun_q, gap_q;
    logic                          orphan_d, short_d, overrun_d, gap_d;
    logic [GW-1:0]                 gap_cnt_q;
    logic                          armed_q;
    logic                          load;

    always_comb begin
        orphan_d  = bus.hsi_valid && !bus.hsi_cmd && (state == IDLE);
        short_d   = bus.hsi_valid &&  bus.hsi_cmd && (state == DATA);
        overrun_d = asm_done && row_valid_q && !bus.row_ready;
        // The counter saturates at GAP_MAX, so "not yet equal" means too soon.
        gap_d     = bus.hsi_valid && bus.hsi_cmd && (state == IDLE) && armed_q
                    && (gap_cnt_q != GAP_MAX);
        load      = asm_done && (!row_valid_q || bus.row_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_valid_q <= 1'b0;
            row_index_q <= '0;
            seg_q       <= '0;
            orphan_q    <= 1'b0;
            short_q     <= 1'b0;
            overrun_q   <= 1'b0;
            gap_q       <= 1'b0;
            gap_cnt_q   <= '0;
            armed_q     <= 1'b0;
        end else begin
            orphan_q  <= orphan_d;
            short_q   <= short_d;
            overrun_q <= overrun_d;
            gap_q     <= gap_d;
            if (load) begin
                row_valid_q <= 1'b1;
                row_index_q <= asm_index;
                seg_q       <= asm_row;
            end else if (row_valid_q && bus.row_ready) begin
                row_valid_q <= 1'b0;
            end
            if (asm_done) begin
                gap_cnt_q <= '0;
                armed_q   <= 1'b1;
            end else if (!bus.hsi_valid && gap_cnt_q != GAP_MAX) begin
                gap_cnt_q <= gap_cnt_q + GW'(1);
            end
        end
    end

`ifdef SMEM_HSI_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge clk) begin
        if (reset)
            err_cnt_q <= '0;
        else if ((orphan_q || short_q || overrun_q || gap_q) && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
    end
    assign err_count = err_cnt_q;
`endif

    assign bus.row_valid  = row_valid_q;
    assign bus.row_index  = row_index_q;
    assign bus.smem_data0 = seg_q[0];
    assign bus.smem_data1 = seg_q[1];
    assign bus.smem_data2 = seg_q[2];
    assign bus.smem_data3 = seg_q[3];
    assign busy           = (state == DATA);
    assign err_orphan     = orphan_q;
    assign err_short      = short_q;
    assign err_overrun    = overrun_q;
    assign err_gap        = gap_q;
endmodule

// File: tb/tb_smem_hsi_receiver.sv
// Directed bench: two receivers (IDLE_MIN=0 and 7) driven by the same HSI stream.
module tb_smem_hsi_receiver;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] hsi_data;
    logic        hsi_cmd, hsi_valid, row_ready;
    logic        busy0, orphan0, short0, overrun0, gap0;
    logic        busy1, orphan1, short1, overrun1, gap1;
`ifdef SMEM_HSI_RX_ERR_CNT_EN
    logic [15:0] err_count0, err_count1;
`endif
    int checks = 0;
    int errors = 0;
    int n_orph0 = 0, n_short0 = 0, n_ovr0 = 0, n_gap0 = 0, n_any1 = 0, n_gap1 = 0;

    always #5 clk = ~clk;

    smem_hsi_receiver_if #(.DW(512)) bus0 ();
    smem_hsi_receiver_if #(.DW(512)) bus1 ();
    assign bus0.hsi_data  = hsi_data;
    assign bus0.hsi_cmd   = hsi_cmd;
    assign bus0.hsi_valid = hsi_valid;
    assign bus0.row_ready = row_ready;
    assign bus1.hsi_data  = hsi_data;
    assign bus1.hsi_cmd   = hsi_cmd;
    assign bus1.hsi_valid = hsi_valid;
    assign bus1.row_ready = row_ready;

    smem_hsi_receiver #(.DW(512), .IDLE_MIN(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .busy(busy0),
        .err_orphan(orphan0), .err_short(short0), .err_overrun(overrun0), .err_gap(gap0)
`ifdef SMEM_HSI_RX_ERR_CNT_EN
        , .err_count(err_count0)
`endif
    );

    smem_hsi_receiver #(.DW(512), .IDLE_MIN(7)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .busy(busy1),
        .err_orphan(orphan1), .err_short(short1), .err_overrun(overrun1), .err_gap(gap1)
`ifdef SMEM_HSI_RX_ERR_CNT_EN
        , .err_count(err_count1)
`endif
    );

    // Pulse-cycle counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            n_orph0  <= n_orph0  + int'(orphan0);
            n_short0 <= n_short0 + int'(short0);
            n_ovr0   <= n_ovr0   + int'(overrun0);
            n_gap0   <= n_gap0   + int'(gap0);
            n_gap1   <= n_gap1   + int'(gap1);
            n_any1   <= n_any1   + int'(orphan1 | short1 | overrun1 | gap1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic c, input logic [31:0] d);
        hsi_valid = 1'b1; hsi_cmd = c; hsi_data = d;
        @(posedge clk); #1;
        hsi_valid = 1'b0; hsi_cmd = 1'b0;
    endtask

    task automatic send_words(input logic [31:0] base, input int cnt);
        for (int n = 0; n < cnt; n++) send(1'b0, base + 32'(n));
    endtask

    task automatic send_row(input logic [31:0] idx, input logic [31:0] base);
        send(1'b1, idx);
        send_words(base, 64);
    endtask

    int s_orph, s_short, s_ovr, s_any0, s_any1;

    initial begin
        reset = 1'b1; hsi_valid = 1'b0; hsi_cmd = 1'b0; hsi_data = '0; row_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_valid", 32'(bus0.row_valid), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_errs", {28'd0, orphan0, short0, overrun0, gap0}, 32'd0);
        chk("rst_index", bus0.row_index, 32'd0);
        chk("rst_data", bus0.smem_data0[31:0], 32'd0);
        reset = 1'b0;
        idle();

        // Basic row
        send(1'b1, 32'h5);
        chk("busy_in_data", 32'(busy0), 32'd1);
        send_words(32'h1000, 63);
        chk("no_valid_before_last", 32'(bus0.row_valid), 32'd0);
        send(1'b0, 32'h103F);
        chk("row1_valid", 32'(bus0.row_valid), 32'd1);
        chk("row1_index", bus0.row_index, 32'h5);
        chk("row1_d0_lo", bus0.smem_data0[31:0], 32'h1000);
        chk("row1_d1_lo", bus0.smem_data1[31:0], 32'h1010);
        chk("row1_d2_hi", bus0.smem_data2[511:480], 32'h102F);
        chk("row1_d3_hi", bus0.smem_data3[511:480], 32'h103F);
        chk("row1_busy", 32'(busy0), 32'd0);
        idle();
        chk("row1_accepted", 32'(bus0.row_valid), 32'd0);

        // Orphan data beats
        s_orph = n_orph0;
        send_words(32'hDEAD0000, 3);
        idle();
        chk("orphan_count", 32'(n_orph0 - s_orph), 32'd3);
        chk("orphan_no_row", 32'(bus0.row_valid), 32'd0);
        send_row(32'h9, 32'h2000);
        chk("row2_index", bus0.row_index, 32'h9);
        chk("row2_d1_hi", bus0.smem_data1[511:480], 32'h201F);
        idle();

        // Short row
        s_short = n_short0;
        send(1'b1, 32'h7);
        send_words(32'h7000, 10);
        send_row(32'h8, 32'h8000);
        chk("short_count", 32'(n_short0 - s_short), 32'd1);
        chk("short_index", bus0.row_index, 32'h8);
        chk("short_w1", bus0.smem_data0[63:32], 32'h8001);
        chk("short_w9", bus0.smem_data0[319:288], 32'h8009);
        chk("short_d3_hi", bus0.smem_data3[511:480], 32'h803F);
        idle();

        // Overrun with consumer stalled
        s_ovr = n_ovr0;
        row_ready = 1'b0;
        send_row(32'hA, 32'hA000);
        chk("held_valid", 32'(bus0.row_valid), 32'd1);
        send_row(32'hB, 32'hB000);
        chk("overrun_pulse", 32'(overrun0), 32'd1);
        chk("overrun_keep_index", bus0.row_index, 32'hA);
        chk("overrun_keep_data", bus0.smem_data0[31:0], 32'hA000);
        idle();
        chk("overrun_one_cycle", 32'(overrun0), 32'd0);
        chk("overrun_count", 32'(n_ovr0 - s_ovr), 32'd1);
        row_ready = 1'b1;
        idle();
        chk("overrun_drain", 32'(bus0.row_valid), 32'd0);

        // Accept in the completion cycle: no overrun
        s_ovr = n_ovr0;
        row_ready = 1'b0;
        send_row(32'hC, 32'hC000);
        send(1'b1, 32'hD);
        send_words(32'hD000, 63);
        chk("hold_C", bus0.row_index, 32'hC);
        row_ready = 1'b1;
        send(1'b0, 32'hD03F);
        chk("swap_valid", 32'(bus0.row_valid), 32'd1);
        chk("swap_index", bus0.row_index, 32'hD);
        chk("swap_d3_hi", bus0.smem_data3[511:480], 32'hD03F);
        idle();
        chk("swap_no_overrun", 32'(n_ovr0 - s_ovr), 32'd0);

        // Idle gap check on the IDLE_MIN=7 instance
        send_row(32'h1F, 32'h1F00);
        repeat (3) idle();
        send(1'b1, 32'h20);
        chk("gap_pulse", 32'(gap1), 32'd1);
        chk("gap_off_dut0", 32'(gap0), 32'd0);
        send_words(32'h2000, 64);
        chk("gap_row_index", bus1.row_index, 32'h20);
        chk("gap_row_valid", 32'(bus1.row_valid), 32'd1);
        repeat (7) idle();
        s_any1 = n_gap1;
        send(1'b1, 32'h21);
        chk("gap_ok_no_pulse", 32'(gap1), 32'd0);
        send_words(32'h2100, 64);
        chk("gap_ok_index", bus1.row_index, 32'h21);
        idle();
        chk("gap_ok_count", 32'(n_gap1 - s_any1), 32'd0);

        // Reset mid-row with a held row present
        row_ready = 1'b0;
        send_row(32'h2F, 32'h2F00);
        send(1'b1, 32'h30);
        send_words(32'h3000, 31);
        reset = 1'b1;
        idle();
        chk("midrst_valid", 32'(bus0.row_valid), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_index", bus0.row_index, 32'd0);
`ifdef SMEM_HSI_RX_ERR_CNT_EN
        chk("midrst_err_count", 32'(err_count0), 32'd0);
        chk("midrst_err_count1", 32'(err_count1), 32'd0);
`endif
        reset = 1'b0;
        row_ready = 1'b1;
        s_any0 = n_orph0 + n_short0 + n_ovr0 + n_gap0;
        s_any1 = n_any1;
        send_row(32'h31, 32'h3100);
        chk("post_rst_index", bus0.row_index, 32'h31);
        chk("post_rst_d0_lo", bus0.smem_data0[31:0], 32'h3100);
        chk("post_rst_index1", bus1.row_index, 32'h31);
        idle();
        idle();
        chk("post_rst_errs0", 32'(n_orph0 + n_short0 + n_ovr0 + n_gap0 - s_any0), 32'd0);
        chk("post_rst_errs1", 32'(n_any1 - s_any1), 32'd0);
        chk("gap_never_dut0", 32'(n_gap0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
